// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared mode encodings and width helper for the clock divider
package clkdiv_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } clk_mode_e;

  // A single-channel build still needs a 1-bit channel select.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/prog_clock_divider_if.sv
// rtl/prog_clock_divider_if.sv - configuration write handshake for the clock divider
interface prog_clock_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  import clkdiv_pkg::*;

  localparam int CH_W = ch_width(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_mode,
    output cfg_ready
  );

endinterface

// File: rtl/div_channel.sv
// rtl/div_channel.sv - one divider channel: counter, shadow divisor/mode, pending flag, outputs
module div_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 40000001
) (
  input  logic             clock_n,
  input  logic             reset_p,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic             pending,
  output logic             div_clk,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'((DEFAULT_DIV == 0) ? 1 : DEFAULT_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] shd_div;
  clk_mode_e        mode_act;
  clk_mode_e        shd_mode;
  logic             terminal;
  logic             apply;
  logic             mode_flip;
  logic [CNT_W-1:0] new_div;

  assign terminal  = en && (cnt == div_act - ONE);
  // A write landing on a terminal cycle only sets pending after that edge, so it waits a period.
  assign apply     = pending && (!en || terminal);
  assign mode_flip = apply && (shd_mode != mode_act);
  assign new_div   = (shd_div == '0) ? ONE : shd_div;

  always_ff @(negedge clock_n) begin
    if (reset_p) begin
      cnt      <= '0;
      div_act  <= DEF_DIV;
      shd_div  <= DEF_DIV;
      mode_act <= MODE_TOGGLE;
      shd_mode <= MODE_TOGGLE;
      pending  <= 1'b0;
      div_clk  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (apply) begin
        div_act  <= new_div;
        mode_act <= shd_mode;
        pending  <= 1'b0;
      end
      if (wr) begin
        shd_div  <= wr_div;
        shd_mode <= clk_mode_e'(wr_mode);
        pending  <= 1'b1;
      end
      if (!en) begin
        cnt     <= '0;
        div_clk <= 1'b0;
        tick    <= 1'b0;
      end else begin
        cnt  <= terminal ? '0 : cnt + ONE;
        tick <= terminal;
        if (mode_flip) begin
          div_clk <= 1'b0;
        end else if (mode_act == MODE_PULSE) begin
          div_clk <= terminal;
        end else if (terminal) begin
          div_clk <= ~div_clk;
        end
      end
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - multi-channel programmable clock divider top (cfg decode + channels)
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 40000001
) (
  input  logic                clock_n,
  input  logic                reset_p,
  input  logic [NUM_CH-1:0]   ch_en,
  prog_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]   div_clk,
  output logic [NUM_CH-1:0]   tick
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int PAD_W = 1 << CH_W;

  logic [NUM_CH-1:0] pending;
  logic [PAD_W-1:0]  pending_pad;
  logic              ready;
  logic              accept;

  // Unused channel codes read as not pending; writes to them are dropped.
  assign pending_pad   = PAD_W'(pending);
  assign ready         = !reset_p && !pending_pad[cfg.cfg_ch];
  assign cfg.cfg_ready = ready;
  assign accept        = cfg.cfg_valid && ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock_n (clock_n),
      .reset_p (reset_p),
      .en      (ch_en[i]),
      .wr      (accept && (cfg.cfg_ch == CH_W'(i))),
      .wr_div  (cfg.cfg_div),
      .wr_mode (cfg.cfg_mode),
      .pending (pending[i]),
      .div_clk (div_clk[i]),
      .tick    (tick[i])
    );
  end

endmodule
